// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one operation in flight.
// Latency: rsp_valid LAT edges after transfer; a stalled rsp_ready holds the response and blocks new grants.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    input  logic             rsp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic [3:0] cnt;
    logic       gnt_id;
    logic       xfer;
    logic       cap;

    // A lone requester wins regardless of prio; prio only breaks ties.
    assign gnt_id     = (req0_valid && req1_valid) ? prio : req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !gnt_id;
    assign req1_ready = (state == IDLE) && req1_valid && gnt_id;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    xfer      = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == CNT_LAST) begin
                    cap       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio       <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (xfer) begin
                alu_a  <= gnt_id ? req1_a  : req0_a;
                alu_b  <= gnt_id ? req1_b  : req0_b;
                alu_op <= gnt_id ? req1_op : req0_op;
                rsp_id <= gnt_id;
                prio   <= ~gnt_id;
                cnt    <= 4'd0;
            end else if ((state == EXEC) && !cap) begin
                cnt <= cnt + 4'd1;
            end
            if (cap) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: LAT=1 instance for arbitration/backpressure/reset, LAT=4 instance against a delayed ALU model.
module tb_alu_arbiter;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] XOR = 4'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0v, r1v, rrdy;
    logic [15:0] r0a, r0b, r1a, r1b;
    logic [3:0]  r0o, r1o;
    logic        r0r, r1r, sv, sid, sbusy;
    logic [15:0] aa, ab, ares, sres;
    logic [3:0]  ao, aflg, sflg;

    logic        q0v, q1v, qrdy;
    logic [15:0] q0a, q0b, q1a, q1b;
    logic [3:0]  q0o, q1o;
    logic        q0r, q1r, qv, qid, qbusy;
    logic [15:0] qa, qb, qres, qsres;
    logic [3:0]  qo, qflg, qsflg;
    logic [19:0] d1, d2, d3;

    int checks   = 0;
    int failures = 0;

    function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic [15:0] r;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            XOR:     r = a ^ b;
            default: r = 16'h0000;
        endcase
        return {(r == 16'h0000), r[15], 2'b00, r};
    endfunction

    assign {aflg, ares} = alu_f(aa, ab, ao);

    always @(posedge clk) begin
        d1 <= alu_f(qa, qb, qo);
        d2 <= d1;
        d3 <= d2;
    end
    assign {qflg, qres} = d3;

    alu_arbiter #(.WIDTH(16), .OPW(4), .LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_op(r0o), .req0_ready(r0r),
        .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_op(r1o), .req1_ready(r1r),
        .alu_a(aa), .alu_b(ab), .alu_op(ao), .alu_result(ares), .alu_flags(aflg),
        .rsp_valid(sv), .rsp_id(sid), .rsp_result(sres), .rsp_flags(sflg),
        .rsp_ready(rrdy), .busy(sbusy)
    );

    alu_arbiter #(.WIDTH(16), .OPW(4), .LAT(4)) u4 (
        .clk(clk), .rst(rst),
        .req0_valid(q0v), .req0_a(q0a), .req0_b(q0b), .req0_op(q0o), .req0_ready(q0r),
        .req1_valid(q1v), .req1_a(q1a), .req1_b(q1b), .req1_op(q1o), .req1_ready(q1r),
        .alu_a(qa), .alu_b(qb), .alu_op(qo), .alu_result(qres), .alu_flags(qflg),
        .rsp_valid(qv), .rsp_id(qid), .rsp_result(qsres), .rsp_flags(qsflg),
        .rsp_ready(qrdy), .busy(qbusy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [35:0] ops;
        logic        eid;
        rst = 1'b0;
        r0v = 0; r1v = 0; rrdy = 0;
        r0a = 0; r0b = 0; r0o = 0; r1a = 0; r1b = 0; r1o = 0;
        q0v = 0; q1v = 0; qrdy = 0;
        q0a = 0; q0b = 0; q0o = 0; q1a = 0; q1b = 0; q1o = 0;

        // reset state
        #1;
        chk("reset_u1", {sv, sid, sres, sflg, aa, ab, ao, sbusy, r0r, r1r}, 64'h0);
        chk("reset_u4", {qv, qid, qsres, qsflg, qa, qb, qo, qbusy}, 64'h0);
        tick(); tick();
        rst = 1'b1;

        // single op from port 0, LAT=1
        r0v = 1; r0a = 16'h0005; r0b = 16'h0003; r0o = ADD;
        #1;
        chk("t1_ready", {r0r, r1r}, 64'b10);
        tick();
        r0v = 0;
        chk("t1_issue", {sv, sbusy, aa, ab, ao}, {2'b01, 16'h0005, 16'h0003, ADD});
        tick();
        chk("t1_rsp", {sv, sid, sres, sflg}, {2'b10, 16'h0008, 4'h0});
        rrdy = 1;
        tick();
        chk("t1_idle", {sv, sbusy}, 64'b00);

        // round-robin with both requesters valid
        rst = 1'b0;
        #1;
        rst = 1'b1;
        r0v = 1; r0a = 16'h0010; r0b = 16'h0001; r0o = SUB;
        r1v = 1; r1a = 16'h00F0; r1b = 16'h0F0F; r1o = AND;
        for (int i = 0; i < 4; i++) begin
            eid = i[0];
            #1;
            chk("rr_ready", {r0r, r1r}, eid ? 64'b01 : 64'b10);
            tick();
            chk("rr_issue", {aa, ao}, eid ? {16'h00F0, AND} : {16'h0010, SUB});
            tick();
            chk("rr_rsp", {sv, sid, sres, sflg},
                eid ? {2'b11, 16'h0000, 4'h8} : {2'b10, 16'h000F, 4'h0});
            tick();
            chk("rr_done", {sv, sbusy}, 64'b00);
        end
        r0v = 0; r1v = 0;

        // back-pressure: response held for 10 cycles
        rrdy = 0;
        r0v = 1; r0a = 16'h7000; r0b = 16'h1000; r0o = ADD;
        #1;
        chk("bp_ready", {r0r, r1r}, 64'b10);
        tick();
        r1v = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {sv, r0r, r1r, sbusy, sflg, sres}, {4'b1001, 4'h4, 16'h8000});
            tick();
        end
        r0v = 0; r1v = 0; rrdy = 1;
        tick();
        chk("bp_release", {sv, sbusy}, 64'b00);

        // one-cycle valid pulse on port 1 during EXEC is ignored
        r0v = 1; r0a = 16'h1234; r0b = 16'h00FF; r0o = XOR;
        tick();
        r0v = 0;
        r1v = 1; r1a = 16'hAAAA; r1b = 16'h5555; r1o = ADD;
        #1;
        chk("gl_noready", {r0r, r1r, sbusy}, 64'b001);
        tick();
        r1v = 0;
        chk("gl_rsp", {sv, sid, sres, sflg}, {2'b10, 16'h12CB, 4'h0});
        tick();
        tick();
        tick();
        chk("gl_idle", {sv, sbusy, aa}, {2'b00, 16'h1234});

        // reset during EXEC
        rrdy = 0;
        r0v = 1; r0a = 16'h0001; r0b = 16'h0002; r0o = ADD;
        tick();
        r0v = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_exec", {sv, sid, sres, sflg, aa, ab, ao, sbusy, r0r, r1r}, 64'h0);
        tick();
        rst = 1'b1;

        // reset during RESP
        r0v = 1;
        tick();
        r0v = 0;
        tick();
        chk("pre_rst_resp", {sv, sres}, {1'b1, 16'h0003});
        #2;
        rst = 1'b0;
        #1;
        chk("rst_resp", {sv, sid, sres, sflg, aa, ab, ao, sbusy, r0r, r1r}, 64'h0);
        tick();
        rst = 1'b1;
        r0v = 1; r1v = 1;
        #1;
        chk("rst_prio", {r0r, r1r}, 64'b10);
        rrdy = 1;
        tick();
        r0v = 0; r1v = 0;
        tick();
        chk("rst_prio_rsp", {sv, sid, sres}, {2'b10, 16'h0003});
        tick();

        // LAT=4 instance against a 3-cycle delayed ALU
        q0v = 1; q0a = 16'h0100; q0b = 16'h0023; q0o = ADD;
        #1;
        chk("l4_ready", {q0r, q1r}, 64'b10);
        tick();
        q0v = 0;
        ops = {qa, qb, qo};
        chk("l4_issue", ops, {16'h0100, 16'h0023, ADD});
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk("l4_wait", {qv, q0r, q1r, qbusy, qa, qb, qo}, {4'b0001, ops});
        end
        tick();
        chk("l4_rsp", {qv, qid, qsflg, qsres, qa, qb, qo}, {2'b10, 4'h0, 16'h0123, ops});
        qrdy = 1;
        tick();
        chk("l4_idle", {qv, qbusy}, 64'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
